// File: rtl/cache_fill_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cache_fill_fsm
// Description : Cache line fill controller. On a miss in IDLE it latches the
//               block-aligned base address, streams WORDS_PER_BLOCK word read
//               requests to memory on consecutive cycles, and writes each
//               returned word into the cache data array in request order.
//               The final word also writes the tag (valid+tag) array, after
//               which the controller returns to IDLE.
//
// Ports       : clk               - system clock, rising edge
//               rst               - asynchronous reset, active low
//               miss_detected     - cache miss for miss_address this cycle
//               miss_address      - word address of the missing access
//               fsm_busy          - fill in progress, pipeline must stall
//               mem_read          - one-word read request to memory
//               memory_address    - word address of the memory request
//               memory_data_valid - memory_data carries a returned word
//               memory_data       - returned word, in request order
//               write_data_array  - cache data array write enable
//               write_tag_array   - cache tag array write enable
//               cache_address     - word address of the cache write
//               cache_data        - word written into the cache
//               miss_count        - number of fills started (optional)
//
// Build option: FILL_MISS_COUNT_EN - when defined, miss_count is a
//               saturating count of fills started; otherwise it is tied to 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_fsm #(
    parameter int unsigned WORDS_PER_BLOCK = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    output logic        fsm_busy,
    output logic        mem_read,
    output logic [15:0] memory_address,
    input  logic        memory_data_valid,
    input  logic [15:0] memory_data,
    output logic        write_data_array,
    output logic        write_tag_array,
    output logic [15:0] cache_address,
    output logic [15:0] cache_data,
    output logic [15:0] miss_count
);

    // Counters need one extra bit so the issue counter can hold the value
    // WORDS_PER_BLOCK, which marks "all requests sent".
    localparam int unsigned c_IDX_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam int unsigned c_CNT_W = c_IDX_W + 1;

    localparam logic [c_CNT_W-1:0] c_WORDS       = c_CNT_W'(WORDS_PER_BLOCK);
    localparam logic [c_CNT_W-1:0] c_LAST        = c_CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [c_CNT_W-1:0] c_ONE         = c_CNT_W'(1);
    localparam logic [15:0]        c_OFFSET_MASK = 16'(WORDS_PER_BLOCK - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_FILL = 1'b1;

    logic [0:0]         state_q,     state_d;
    logic [15:0]        base_q,      base_d;
    logic [c_CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [c_CNT_W-1:0] recv_cnt_q,  recv_cnt_d;

    logic w_start;
    logic w_issue_active;
    logic w_recv_active;
    logic w_last_word;

    assign w_start        = (state_q == c_IDLE) && miss_detected;
    assign w_issue_active = (state_q == c_FILL) && (issue_cnt_q < c_WORDS);
    // Returned data outside FILL is ignored entirely.
    assign w_recv_active  = (state_q == c_FILL) && memory_data_valid;
    assign w_last_word    = w_recv_active && (recv_cnt_q == c_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= c_IDLE;
            base_q      <= 16'h0000;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;

        case (state_q)
            c_IDLE: begin
                if (w_start) begin
                    state_d     = c_FILL;
                    base_d      = miss_address & ~c_OFFSET_MASK;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                end
            end
            c_FILL: begin
                // Request issue and data return run independently, so both
                // counters may advance in the same cycle.
                if (w_issue_active) begin
                    issue_cnt_d = issue_cnt_q + c_ONE;
                end
                if (w_recv_active) begin
                    recv_cnt_d = recv_cnt_q + c_ONE;
                end
                if (w_last_word) begin
                    state_d = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (all outputs idle at zero)
    // ------------------------------------------------------------------
    always_comb begin
        fsm_busy         = 1'b0;
        mem_read         = 1'b0;
        memory_address   = 16'h0000;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        cache_address    = 16'h0000;
        cache_data       = 16'h0000;

        if (state_q == c_FILL) begin
            fsm_busy = 1'b1;
        end
        // base is block aligned, so adding the counter never carries out
        // of the block.
        if (w_issue_active) begin
            mem_read       = 1'b1;
            memory_address = base_q + 16'(issue_cnt_q);
        end
        if (w_recv_active) begin
            write_data_array = 1'b1;
            cache_address    = base_q + 16'(recv_cnt_q);
            cache_data       = memory_data;
            write_tag_array  = w_last_word;
        end
    end

    // ------------------------------------------------------------------
    // Optional fill statistics
    // ------------------------------------------------------------------
`ifdef FILL_MISS_COUNT_EN
    logic [15:0] miss_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_count_q <= 16'h0000;
        end else if (w_start && (miss_count_q != 16'hFFFF)) begin
            miss_count_q <= miss_count_q + 16'h0001;
        end
    end

    assign miss_count = miss_count_q;
`else
    assign miss_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cache_fill_fsm
// Description : Self-checking bench for cache_fill_fsm. A driver issues
//               misses and plays a memory that answers requests after a
//               latency; a block-level model pushes the expected requests
//               and cache writes into queues, and a monitor on the falling
//               edge pops and compares whatever the DUT presents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_fill_fsm;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        mem_read;
    logic [15:0] memory_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] cache_address;
    logic [15:0] cache_data;
    logic [15:0] miss_count;

    always #5 clk = ~clk;

    cache_fill_fsm #(.WORDS_PER_BLOCK(W)) u_dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .mem_read          (mem_read),
        .memory_address    (memory_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .cache_address     (cache_address),
        .cache_data        (cache_data),
        .miss_count        (miss_count)
    );

    typedef struct {
        int          rdy;
        logic [15:0] a;
    } mem_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        logic        t;
    } wr_t;

    mem_t        mem_q[$];       // outstanding memory requests
    logic [15:0] exp_req_q[$];   // expected request addresses
    wr_t         exp_wr_q[$];    // expected cache writes

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Block-level reference model state
    bit          m_fill   = 1'b0;
    int          m_age    = 0;
    int          m_recv   = 0;
    int          m_fills  = 0;
    int          m_done   = 0;
    logic [15:0] m_base   = 16'h0;
    logic [15:0] m_mcount = 16'h0;

    // Stimulus knobs
    int p_miss_idle = 0;
    int p_miss_fill = 0;
    int p_gap       = 0;
    int p_stray     = 0;
    int lat_min     = 4;
    int lat_max     = 4;
    int gap_at      = -1;
    int gap_left    = 0;

    // Monitor statistics
    int busy_run      = 0;
    int last_busy_run = 0;
    int idle_run      = 0;
    int last_idle_run = 0;
    int tag_cnt       = 0;

    logic mon_exp_rd;
    logic mon_exp_wr;
    wr_t  mon_w;
    mem_t mon_m;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic fail(input string nm, input logic [15:0] act);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d: got %h, expected none", nm, cyc, act);
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        check("fsm_busy", fsm_busy, m_fill);
        mon_exp_rd = m_fill && (m_age < W);
        check("mem_read", mem_read, mon_exp_rd);
        if (mem_read) begin
            if (exp_req_q.size() == 0) begin
                fail("req_unexpected", memory_address);
            end else begin
                check("req_addr", memory_address, exp_req_q.pop_front());
            end
            mon_m.rdy = cyc + $urandom_range(lat_min, lat_max);
            mon_m.a   = memory_address;
            mem_q.push_back(mon_m);
        end else begin
            check("req_addr_idle", memory_address, 16'h0);
        end

        mon_exp_wr = m_fill && memory_data_valid && rst;
        check("write_data_array", write_data_array, mon_exp_wr);
        if (write_data_array) begin
            if (exp_wr_q.size() == 0) begin
                fail("write_unexpected", cache_address);
            end else begin
                mon_w = exp_wr_q.pop_front();
                check("cache_address", cache_address, mon_w.a);
                check("cache_data", cache_data, mon_w.d);
                check("write_tag_array", write_tag_array, mon_w.t);
            end
        end else begin
            check("cache_address_idle", cache_address, 16'h0);
            check("cache_data_idle", cache_data, 16'h0);
            check("write_tag_idle", write_tag_array, 1'b0);
        end
        if (write_tag_array) tag_cnt++;
        check("miss_count", miss_count, m_mcount);

        if (fsm_busy) begin
            if (idle_run > 0) last_idle_run = idle_run;
            idle_run = 0;
            busy_run++;
        end else begin
            if (busy_run > 0) last_busy_run = busy_run;
            busy_run = 0;
            idle_run++;
        end
    end

    // ------------------------------------------------------------------
    // Driver: advance one cycle, update model, choose new inputs
    // ------------------------------------------------------------------
    task automatic step();
        mem_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            if (m_fill) begin
                if (m_age < W) m_age++;
                if (memory_data_valid) begin
                    m_recv++;
                    if (m_recv == W) begin
                        m_fill = 1'b0;
                        m_done++;
                    end
                end
            end else if (miss_detected) begin
                m_base = miss_address & ~16'(W - 1);
                check("leftover_writes", 16'(exp_wr_q.size()), 16'h0);
                exp_wr_q.delete();
                exp_req_q.delete();
                for (int i = 0; i < W; i++) begin
                    exp_req_q.push_back(m_base + 16'(i));
                    exp_wr_q.push_back('{m_base + 16'(i), mem_word(m_base + 16'(i)), (i == W - 1)});
                end
                m_fill = 1'b1;
                m_age  = 0;
                m_recv = 0;
                m_fills++;
`ifdef FILL_MISS_COUNT_EN
                if (m_mcount != 16'hFFFF) m_mcount = m_mcount + 16'h1;
`endif
            end
        end

        miss_detected = 1'b0;
        miss_address  = 16'($urandom);
        if (!m_fill && ($urandom_range(0, 99) < p_miss_idle)) miss_detected = 1'b1;
        if (m_fill && ($urandom_range(0, 99) < p_miss_fill)) miss_detected = 1'b1;

        memory_data_valid = 1'b0;
        memory_data       = 16'h0;
        if (m_fill) begin
            if (gap_left > 0 && m_recv == gap_at) begin
                gap_left--;
            end else if (mem_q.size() > 0 && mem_q[0].rdy <= cyc &&
                         $urandom_range(0, 99) >= p_gap) begin
                e = mem_q.pop_front();
                memory_data_valid = 1'b1;
                memory_data       = mem_word(e.a);
            end
        end else if ($urandom_range(0, 99) < p_stray) begin
            memory_data_valid = 1'b1;
            memory_data       = 16'($urandom);
        end
    endtask

    task automatic issue_miss(input logic [15:0] addr);
        step();
        miss_detected = 1'b1;
        miss_address  = addr;
    endtask

    task automatic wait_fill_done(input int max);
        int n = 0;
        step();
        while (m_fill && n < max) begin
            step();
            n++;
        end
        if (m_fill) fail("timeout_fill", 16'(m_recv));
    endtask

    task automatic wait_recv(input int cnt, input int max);
        int n = 0;
        step();
        while (m_fill && m_recv < cnt && n < max) begin
            step();
            n++;
        end
        if (m_recv < cnt) fail("timeout_recv", 16'(m_recv));
    endtask

    // Assert reset between edges, confirm outputs clear immediately.
    task automatic do_reset();
        #2;
        rst               = 1'b0;
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0;
        #1;
        check("rst_busy", fsm_busy, 1'b0);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_memory_address", memory_address, 16'h0);
        check("rst_write_data", write_data_array, 1'b0);
        check("rst_write_tag", write_tag_array, 1'b0);
        check("rst_cache_address", cache_address, 16'h0);
        check("rst_cache_data", cache_data, 16'h0);
        check("rst_miss_count", miss_count, 16'h0);
        m_fill   = 1'b0;
        m_mcount = 16'h0;
        gap_left = 0;
        exp_req_q.delete();
        exp_wr_q.delete();
        mem_q.delete();
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: got timeout, expected completion", cyc);
        $fatal(1);
    end

    initial begin
        int f0;
        int tags_before;
        int n;

        rst               = 1'b0;
        miss_detected     = 1'b0;
        miss_address      = 16'h0;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0;
        #1;
        check("init_busy", fsm_busy, 1'b0);
        check("init_mem_read", mem_read, 1'b0);
        check("init_write_data", write_data_array, 1'b0);
        check("init_write_tag", write_tag_array, 1'b0);
        check("init_miss_count", miss_count, 16'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic fill, memory latency 4, no gaps
        step();
        issue_miss(16'h1235);
        wait_fill_done(100);
        step();
        check("busy_len_basic", 16'(last_busy_run), 16'd12);

        // Three-cycle hole in returned data after the third word
        gap_at   = 3;
        gap_left = 3;
        issue_miss(16'($urandom));
        wait_fill_done(100);
        step();
        check("busy_len_gap", 16'(last_busy_run), 16'd15);
        gap_at = -1;

        // Misses during FILL and stray data in IDLE must be ignored
        p_miss_fill = 50;
        issue_miss(16'($urandom));
        wait_fill_done(100);
        p_miss_fill = 0;
        p_stray     = 60;
        f0 = m_fills;
        repeat (12) step();
        p_stray = 0;
        check("no_fill_from_stray", 16'(m_fills), 16'(f0));

        // Reset after the fifth returned word abandons the fill
        issue_miss(16'($urandom));
        wait_recv(5, 100);
        tags_before = tag_cnt;
        do_reset();
        check("no_tag_after_reset", 16'(tag_cnt), 16'(tags_before));
        step();
        issue_miss(16'h00F8);
        wait_fill_done(100);
        step();
        check("busy_len_after_reset", 16'(last_busy_run), 16'd12);

        // Back-to-back misses: second miss in first IDLE cycle
        step();
        do_reset();
        step();
        f0 = m_fills;
        issue_miss(16'h4321);
        p_miss_idle = 100;
        n = 0;
        while (m_fills < f0 + 2 && n < 200) begin
            step();
            n++;
        end
        p_miss_idle = 0;
        if (m_fills < f0 + 2) fail("timeout_b2b", 16'(m_fills - f0));
        wait_fill_done(100);
        step();
        check("b2b_idle_gap", 16'(last_idle_run), 16'd1);
`ifdef FILL_MISS_COUNT_EN
        check("miss_count_b2b", miss_count, 16'd2);
`else
        check("miss_count_b2b", miss_count, 16'd0);
`endif

        // Randomised traffic with variable latency, gaps and one reset
        lat_min     = 1;
        lat_max     = 6;
        p_miss_idle = 30;
        p_miss_fill = 10;
        p_gap       = 25;
        p_stray     = 20;
        for (int i = 0; i < 400; i++) begin
            step();
            if (i == 200) do_reset();
        end
        p_miss_idle = 0;
        p_miss_fill = 0;
        p_gap       = 0;
        p_stray     = 0;
        wait_fill_done(200);
        step();
        check("tag_count_total", 16'(tag_cnt), 16'(m_done));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameter: WORDS_PER_BLOCK, default 8, number of 16-bit words per cache block; power of two, 2..16.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 miss_detected  input  1  cache reports a miss for miss_address this cycle.
REQ-005 miss_address  input  16  word address of the missing access.
REQ-006 fsm_busy  output  1  fill in progress; pipeline must stall.
REQ-007 mem_read  output  1  read request to memory, one word per asserted cycle.
REQ-008 memory_address  output  16  word address of the current memory request.
REQ-009 memory_data_valid  input  1  memory_data carries a returned word this cycle.
REQ-010 memory_data  input  16  returned memory word, in request order.
REQ-011 write_data_array  output  1  write enable to the cache data array.
REQ-012 write_tag_array  output  1  write enable to the cache meta-data (valid+tag) array.
REQ-013 cache_address  output  16  word address for the cache write.
REQ-014 cache_data  output  16  word written into the cache.
REQ-015 miss_count  output  16  fill statistics counter (see Configuration).

Function
REQ-016 Two states: IDLE, FILL.
REQ-017 IDLE: when miss_detected=1, the block SHALL latch base = miss_address with its low log2(WORDS_PER_BLOCK) bits cleared, clear both counters, and enter FILL next cycle.
REQ-018 FILL: fsm_busy=1 combinationally from state; fsm_busy=0 in IDLE.
REQ-019 Issue counter: while issue_cnt < WORDS_PER_BLOCK, mem_read=1 and memory_address = base + issue_cnt; issue_cnt increments each cycle; afterwards mem_read=0.
REQ-020 First request SHALL issue in the first FILL cycle (one cycle after miss_detected is sampled).
REQ-021 Receive counter: each cycle in FILL with memory_data_valid=1, write_data_array=1, cache_address = base + recv_cnt, cache_data = memory_data, recv_cnt increments; all combinational same-cycle.
REQ-022 On the valid word where recv_cnt = WORDS_PER_BLOCK-1, write_tag_array SHALL also be 1 that cycle, and state returns to IDLE next cycle.
REQ-023 Request issue and data return may overlap in the same cycle; both counters advance independently.
REQ-024 miss_detected while in FILL SHALL be ignored; memory_data_valid while in IDLE SHALL be ignored (no writes).
REQ-025 Address arithmetic is 16-bit; base + counter never carries out of the block because base is block-aligned.
REQ-026 Outside REQ-019/REQ-021/REQ-022 conditions, mem_read, write_data_array, write_tag_array SHALL be 0; memory_address, cache_address, cache_data SHALL be 16'h0000.
REQ-027 A new miss presented in the cycle after returning to IDLE SHALL start a new fill normally (no dead cycles beyond that).

Reset
REQ-028 rst=0 SHALL immediately force state IDLE, base=0, issue_cnt=0, recv_cnt=0, miss_count=0, hence all outputs 0, independent of clk.
REQ-029 Reset during FILL abandons the fill; no tag write occurs; words already written remain but tag stays invalid.

Configuration
REQ-030 Macro FILL_MISS_COUNT_EN: when defined, miss_count increments by 1 each IDLE->FILL transition, saturating at 16'hFFFF; when undefined, miss_count is tied to 16'h0000 and no counter register exists.

Verification
REQ-031 Miss at 16'h1235, memory returns words 4 cycles after each request -> requests to 16'h1230..16'h1237 on 8 consecutive cycles; 8 cache writes at 16'h1230..16'h1237 with matching data; write_tag_array only with the write to 16'h1237; fsm_busy high 12 cycles.
REQ-032 memory_data_valid held low 3 cycles mid-fill after word 3 -> no writes during gap; remaining words written in order; fill completes at 8th valid.
REQ-033 miss_detected pulsed during FILL and memory_data_valid pulsed in IDLE -> no new fill started, no cache writes.
REQ-034 rst asserted after 5th returned word -> all outputs 0 asynchronously; write_tag_array never asserted; next miss at 16'h00F8 fills 16'h00F8..16'h00FF cleanly.
REQ-035 Back-to-back misses (second miss_detected in first IDLE cycle) -> second fill's first request one cycle later; with FILL_MISS_COUNT_EN miss_count = 2, without it miss_count = 0.
